// File: rtl/ddr4_dm_lane_tx_ctrl.sv
// ddr4_dm_lane_tx_ctrl
//
// Fabric-side controller for the DDR4 data-mask output lanes. The TX half
// turns a write-mask beat stream into per-lane 8-UI TX_DATA words with 4-bit
// OE_DATA enables, framed by one preamble and one postamble cycle. The step
// half sequences per-lane TX delay-line tap moves and loads behind a
// 4-phase request/acknowledge handshake and keeps a shadow tap per lane.
//
// Ports:
//   FAB_CLK, SYNC_RST          fabric clock, synchronous active-high reset
//   WR_VALID/WR_DM/WR_LAST     write-mask beat stream (lane l = WR_DM[8l+7:8l])
//   WR_READY                   beat accepted when high together with WR_VALID
//   TX_DATA, OE_DATA           per-lane IOD data and output-enable words
//   STEP_REQ/LANE/DIR/LOAD     tap-operation request (LOAD beats DIR)
//   STEP_ACK, STEP_ERR         one-cycle completion pulse, error qualifier
//   DELAY_LINE_MOVE/DIRECTION/LOAD   per-lane IOD delay-line controls
//   DELAY_LINE_OUT_OF_RANGE    per-lane IOD range flag
//   TAP_CNT                    shadow tap per lane, TAP_W bits each
module ddr4_dm_lane_tx_ctrl #(
    parameter int LANES    = 2,
    parameter int TAP_W    = 7,
    parameter int TAP_MAX  = 127,
    parameter int TAP_INIT = 1,
    parameter int MOVE_GAP = 4
) (
    input  logic                                        FAB_CLK,
    input  logic                                        SYNC_RST,
    input  logic                                        WR_VALID,
    input  logic [LANES*8-1:0]                          WR_DM,
    input  logic                                        WR_LAST,
    output logic                                        WR_READY,
    output logic [LANES*8-1:0]                          TX_DATA,
    output logic [LANES*4-1:0]                          OE_DATA,
    input  logic                                        STEP_REQ,
    input  logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] STEP_LANE,
    input  logic                                        STEP_DIR,
    input  logic                                        STEP_LOAD,
    output logic                                        STEP_ACK,
    output logic                                        STEP_ERR,
    output logic [LANES-1:0]                            DELAY_LINE_MOVE,
    output logic [LANES-1:0]                            DELAY_LINE_DIRECTION,
    output logic [LANES-1:0]                            DELAY_LINE_LOAD,
    input  logic [LANES-1:0]                            DELAY_LINE_OUT_OF_RANGE,
    output logic [LANES*TAP_W-1:0]                      TAP_CNT
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int GAP_W  = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;
    localparam logic [TAP_W-1:0] TAP_MAX_V  = TAP_W'(TAP_MAX);
    localparam logic [TAP_W-1:0] TAP_INIT_V = TAP_W'(TAP_INIT);

    typedef enum logic [1:0] {IDLE, PRE, BURST, POST} tx_state_t;
    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT, S_ACK} step_state_t;

    tx_state_t   tx_state;
    step_state_t step_state;

    logic [TAP_W-1:0]  tap [LANES];
    logic [LANE_W-1:0] lane_q;
    logic              dir_q;
    logic              load_q;
    logic [GAP_W-1:0]  gap_cnt;
    logic              armed;     // STEP_REQ seen low since the last ACK

    // ------------------------------------------------------------------
    // TX FSM. WR_READY rises together with the preamble, so the first beat
    // can already be taken in PRE and lands on TX_DATA right after it.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            tx_state <= IDLE;
            TX_DATA  <= '0;
            OE_DATA  <= '0;
            WR_READY <= 1'b0;
        end else begin
            case (tx_state)
                IDLE: begin
                    TX_DATA  <= '0;
                    OE_DATA  <= '0;
                    WR_READY <= 1'b0;
                    if (WR_VALID) begin
                        tx_state <= PRE;
                        OE_DATA  <= '1;
                        WR_READY <= 1'b1;
                    end
                end
                PRE, BURST: begin
                    OE_DATA <= '1;
                    if (WR_VALID) begin
                        TX_DATA <= WR_DM;
                        if (WR_LAST) begin
                            tx_state <= POST;
                            WR_READY <= 1'b0;
                        end else begin
                            tx_state <= BURST;
                        end
                    end else begin
                        // bubble: keep the lane driven, send no mask
                        TX_DATA  <= '0;
                        tx_state <= BURST;
                    end
                end
                POST: begin
                    OE_DATA  <= '1;
                    TX_DATA  <= '0;
                    tx_state <= IDLE;
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Request qualification against the addressed lane's current state.
    // ------------------------------------------------------------------
    logic             lane_ok;
    logic [TAP_W-1:0] cur_tap;
    logic             cur_oor;
    logic             reject;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        lane_ok = (int'(STEP_LANE) < LANES);
        cur_tap = '0;
        cur_oor = 1'b0;
        if (lane_ok) begin
            cur_tap = tap[STEP_LANE];
            cur_oor = DELAY_LINE_OUT_OF_RANGE[STEP_LANE];
        end
        reject = !lane_ok ||
                 (!STEP_LOAD && (cur_oor ||
                                 ( STEP_DIR && cur_tap == TAP_MAX_V) ||
                                 (!STEP_DIR && cur_tap == '0)));
    end

    // ------------------------------------------------------------------
    // Step FSM.
    // ------------------------------------------------------------------
    // NOTE: the tap array is a handful of flops, not a RAM; it must come up
    // at TAP_INIT to mirror the IOD static delay, so it is reset.
    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            step_state           <= S_IDLE;
            STEP_ACK             <= 1'b0;
            STEP_ERR             <= 1'b0;
            DELAY_LINE_MOVE      <= '0;
            DELAY_LINE_DIRECTION <= '0;
            DELAY_LINE_LOAD      <= '0;
            armed                <= 1'b0;
            gap_cnt              <= '0;
            lane_q               <= '0;
            dir_q                <= 1'b0;
            load_q               <= 1'b0;
            for (int l = 0; l < LANES; l++) tap[l] <= TAP_INIT_V;
        end else begin
            DELAY_LINE_MOVE <= '0;
            DELAY_LINE_LOAD <= '0;
            STEP_ACK        <= 1'b0;
            STEP_ERR        <= 1'b0;
            if (!STEP_REQ) armed <= 1'b1;

            case (step_state)
                S_IDLE: begin
                    if (STEP_REQ && armed) begin
                        lane_q <= STEP_LANE;
                        dir_q  <= STEP_DIR;
                        load_q <= STEP_LOAD;
                        if (reject) begin
                            step_state <= S_ACK;
                            STEP_ACK   <= 1'b1;
                            STEP_ERR   <= 1'b1;
                        end else begin
                            step_state <= S_PULSE;
                            if (STEP_LOAD) begin
                                DELAY_LINE_LOAD[STEP_LANE] <= 1'b1;
                            end else begin
                                DELAY_LINE_MOVE[STEP_LANE]      <= 1'b1;
                                DELAY_LINE_DIRECTION[STEP_LANE] <= STEP_DIR;
                            end
                        end
                    end
                end
                S_PULSE: begin
                    // range was checked on acceptance, so no wrap is possible
                    if (load_q)     tap[lane_q] <= TAP_INIT_V;
                    else if (dir_q) tap[lane_q] <= tap[lane_q] + TAP_W'(1);
                    else            tap[lane_q] <= tap[lane_q] - TAP_W'(1);
                    gap_cnt    <= GAP_W'(MOVE_GAP - 1);
                    step_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (gap_cnt == '0) begin
                        step_state           <= S_ACK;
                        STEP_ACK             <= 1'b1;
                        DELAY_LINE_DIRECTION <= '0;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                S_ACK: begin
                    // a low REQ during the ACK cycle already re-arms
                    armed      <= !STEP_REQ;
                    step_state <= S_IDLE;
                end
                default: step_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        TAP_CNT = '0;
        for (int l = 0; l < LANES; l++) TAP_CNT[l*TAP_W +: TAP_W] = tap[l];
    end

endmodule
